lsu_port_arbiter: RTL and testbench
===================================

Name: lsu_port_arbiter

Overview:
- Shares the single LSU port between two requesters: requester 0 is the pipeline MEM stage, requester 1 is the debug/program loader.
- Accepts one transaction at a time over a valid/ready handshake and arbitrates between the requesters.
- Checks the address and alignment, drives the LSU address/func/store lines, and returns load data or a write acknowledgement on a one-cycle response strobe to the requester that issued the transaction.
- Sits between the pipeline/debug logic and the lsu block.

Parameters:
- ADDR_WIDTH, 32, address width of requests and the LSU address.
- DATA_WIDTH, 32, store/load data width.
- LD_LATENCY, 1, cycles from LSU address presentation to valid lsu_ld_data_i. Legal range 0..3.
- MAX_WAIT, 4, consecutive lost-arbitration cycles after which requester 1 is forced to win. Must be ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req0_valid_i / req1_valid_i  in  1  request valid.
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle.
- req0_addr_i / req1_addr_i  in  ADDR_WIDTH  byte address.
- req0_func_i / req1_func_i  in  3  RISC-V funct3 size code.
- req0_wr_i / req1_wr_i  in  1  1 = store, 0 = load.
- req0_wdata_i / req1_wdata_i  in  DATA_WIDTH  store data.
- rsp0_valid_o / rsp1_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  DATA_WIDTH  load data. 0 for stores and errors.
- rsp_err_o  out  1  transaction rejected; qualified by rspN_valid_o.
- lsu_addr_o  out  ADDR_WIDTH  LSU address.
- lsu_func_o  out  3  LSU funct3.
- lsu_st_en_o  out  1  LSU store enable.
- lsu_st_data_o  out  DATA_WIDTH  LSU store data.
- lsu_ld_data_i  in  DATA_WIDTH  LSU load data.

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE, starvation counter 0.
  - All outputs 0, including ready, rsp, err, rdata and all lsu_* lines.
  - Asserting reset mid-transaction drops the transaction: no response, no further lsu_st_en_o.
- States:
  - IDLE: no transaction in progress.
  - BUSY: LSU access in progress.
  - RESP: response strobe cycle.
- IDLE arbitration (combinational):
  - Requester 0 wins a simultaneous request unless starv_cnt == MAX_WAIT; then requester 1 wins.
  - Only the winner's readyN_o is high, and only in IDLE.
  - Handshake = validN & readyN at cycle T. The request fields (addr, func, wr, wdata, id) are latched at the clock edge ending T.
- Starvation counter:
  - Increments in IDLE cycles where req1_valid_i=1 and requester 0 is granted. Saturates at MAX_WAIT.
  - Cleared on a requester-1 grant, or on any cycle with req1_valid_i=0.
- Error check, at handshake:
  - addr[11:8] ≥ 10 → error.
  - Store to addr[11:8]==9 (input-peripheral region) → error.
  - func 010 with addr[1:0]≠0 → error.
  - func 001/101 with addr[0]≠0 → error.
  - Store with func ∉ {000,001,010} → error.
  - Load with func ∉ {000,001,010,100,101} → error.
  - On error the next state is RESP with rsp_err_o=1. The lsu_* outputs stay 0.
- BUSY:
  - lsu_addr_o, lsu_func_o and lsu_st_data_o are driven from the latched request for the whole state.
  - Store: BUSY lasts 1 cycle (T+1). lsu_st_en_o=1 only in that cycle.
  - Load: BUSY lasts LD_LATENCY+1 cycles (T+1 .. T+1+LD_LATENCY). lsu_st_en_o stays 0.
  - lsu_ld_data_i is registered at the edge ending the last BUSY cycle.
  - In any state other than BUSY, all lsu_* outputs are 0.
- RESP:
  - Exactly one cycle. rspN_valid_o=1 for the latched id, with rsp_rdata_o and rsp_err_o.
  - Next state is IDLE.
  - ready is never asserted in RESP, so a new handshake is earliest one cycle after RESP.
- Response latency from handshake T:
  - Load: rsp in cycle T+2+LD_LATENCY.
  - Store: rsp in T+2.
  - Error: rsp in T+1.
- Requester valid may drop before ready without effect; nothing is latched without a handshake.

Test Plan:
- Reset behaviour: hold rst_ni=0 for 3 cycles with both valid=1 → all outputs 0. Release → req0_ready_o=1 in the first IDLE cycle.
- Store to 0x0000_0104 with func 010, wdata 0xDEADBEEF, from req0 at T:
  - T+1: lsu_addr_o=0x104, lsu_st_en_o=1, lsu_st_data_o=0xDEADBEEF.
  - T+2: rsp0_valid_o=1, rsp_err_o=0, rsp_rdata_o=0.
- Load from 0x0000_0900 by req1 with LD_LATENCY=1:
  - LSU returns 0x0000_00A5 in T+2.
  - T+3: rsp1_valid_o=1, rsp_rdata_o=0xA5.
  - lsu_st_en_o never 1.
- Starvation with MAX_WAIT=4: req0 and req1 both continuously valid.
  - req0 wins until the counter reaches 4; the next arbitration grants req1.
  - Counter returns to 0 after the req1 grant.
- Errors:
  - Load func 010 at 0x0000_0102 → rsp at T+1 with rsp_err_o=1, lsu_* all 0.
  - Store at 0x0000_0A00 → rsp at T+1 with rsp_err_o=1, lsu_* all 0.
  - Store at 0x0000_0900 → rsp at T+1 with rsp_err_o=1, lsu_* all 0.
- Reset mid-load: pull rst_ni low during BUSY → outputs 0 immediately. No rsp after release. Next request is served normally.

Source files
------------

// File: rtl/lsu_port_arbiter.sv
// Two-requester arbiter in front of the LSU port: one transaction at a time,
// address/alignment screening, and a single-cycle response strobe to the issuer.
module lsu_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LD_LATENCY = 1,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [2:0]            req0_func_i,
    input  logic                  req0_wr_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [2:0]            req1_func_i,
    input  logic                  req1_wr_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,

    output logic                  rsp0_valid_o,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,

    output logic [ADDR_WIDTH-1:0] lsu_addr_o,
    output logic [2:0]            lsu_func_o,
    output logic                  lsu_st_en_o,
    output logic [DATA_WIDTH-1:0] lsu_st_data_o,
    input  logic [DATA_WIDTH-1:0] lsu_ld_data_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_e;

    localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [1:0]      LAT_LAST = 2'(LD_LATENCY);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        starv_q, starv_d;
    logic [1:0]              lat_q, lat_d;
    logic                    id_q, id_d;
    logic                    wr_q, wr_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              func_q, func_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    grant0, grant1;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [2:0]              sel_func;
    logic                    sel_wr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // Region 0xA..0xF is unmapped, region 0x9 is the read-only input peripheral.
    function automatic logic req_error(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [2:0]            func,
                                       input logic                  wr);
        logic [3:0] region;
        logic       misaligned;
        logic       bad_func;
        region     = addr[11:8];
        misaligned = ((func == 3'b010) && (addr[1:0] != 2'b00)) ||
                     (((func == 3'b001) || (func == 3'b101)) && addr[0]);
        if (wr) begin
            bad_func = !(func inside {3'b000, 3'b001, 3'b010});
        end else begin
            bad_func = !(func inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        return (region >= 4'd10) || (wr && (region == 4'd9)) || misaligned || bad_func;
    endfunction

    // Ready is held low while reset is asserted so the port looks dead during reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if ((state_q == S_IDLE) && rst_ni) begin
            if (req1_valid_i && (!req0_valid_i || (starv_q == CNT_MAX))) begin
                grant1 = 1'b1;
            end else if (req0_valid_i) begin
                grant0 = 1'b1;
            end
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    assign sel_addr  = grant1 ? req1_addr_i  : req0_addr_i;
    assign sel_func  = grant1 ? req1_func_i  : req0_func_i;
    assign sel_wr    = grant1 ? req1_wr_i    : req0_wr_i;
    assign sel_wdata = grant1 ? req1_wdata_i : req0_wdata_i;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        starv_d = starv_q;
        lat_d   = lat_q;
        id_d    = id_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        func_d  = func_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    id_d    = grant1;
                    addr_d  = sel_addr;
                    func_d  = sel_func;
                    wr_d    = sel_wr;
                    wdata_d = sel_wdata;
                    err_d   = req_error(sel_addr, sel_func, sel_wr);
                    rdata_d = '0;
                    lat_d   = 2'd0;
                    state_d = err_d ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (wr_q || (lat_q == LAT_LAST)) begin
                    state_d = S_RESP;
                    if (!wr_q) begin
                        rdata_d = lsu_ld_data_i;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!req1_valid_i || grant1) begin
            starv_d = '0;
        end else if (grant0 && (starv_q != CNT_MAX)) begin
            starv_d = starv_q + CNT_W'(1);
        end
    end

    // Outputs are pure functions of the state, so reset forces them all low at once.
    always_comb begin
        rsp0_valid_o  = 1'b0;
        rsp1_valid_o  = 1'b0;
        rsp_rdata_o   = '0;
        rsp_err_o     = 1'b0;
        lsu_addr_o    = '0;
        lsu_func_o    = 3'b000;
        lsu_st_en_o   = 1'b0;
        lsu_st_data_o = '0;
        if (state_q == S_BUSY) begin
            lsu_addr_o    = addr_q;
            lsu_func_o    = func_q;
            lsu_st_en_o   = wr_q;
            lsu_st_data_o = wdata_q;
        end else if (state_q == S_RESP) begin
            rsp0_valid_o = !id_q;
            rsp1_valid_o = id_q;
            rsp_rdata_o  = rdata_q;
            rsp_err_o    = err_q;
        end
    end

    // NOTE: the request holding registers are reset along with the control
    // state; there are only a handful, and it keeps every output defined.
    // NOTE: state updates use non-blocking assignments so all flops sample
    // the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            starv_q <= '0;
            lat_q   <= 2'd0;
            id_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            func_q  <= 3'b000;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            starv_q <= starv_d;
            lat_q   <= lat_d;
            id_q    <= id_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            func_q  <= func_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Self-checking bench for lsu_port_arbiter: a timeline model of each transaction
// checked every cycle, plus directed scenarios with literal expectations.
module tb_lsu_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 1;
    localparam int MW  = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req0_valid_i, req1_valid_i;
    logic          req0_ready_o, req1_ready_o;
    logic [AW-1:0] req0_addr_i, req1_addr_i;
    logic [2:0]    req0_func_i, req1_func_i;
    logic          req0_wr_i, req1_wr_i;
    logic [DW-1:0] req0_wdata_i, req1_wdata_i;
    logic          rsp0_valid_o, rsp1_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] lsu_addr_o;
    logic [2:0]    lsu_func_o;
    logic          lsu_st_en_o;
    logic [DW-1:0] lsu_st_data_o;
    logic [DW-1:0] lsu_ld_data_i = '0;

    lsu_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LD_LATENCY(LAT), .MAX_WAIT(MW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_addr_i(req0_addr_i), .req0_func_i(req0_func_i),
        .req0_wr_i(req0_wr_i), .req0_wdata_i(req0_wdata_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_addr_i(req1_addr_i), .req1_func_i(req1_func_i),
        .req1_wr_i(req1_wr_i), .req1_wdata_i(req1_wdata_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .lsu_addr_o(lsu_addr_o), .lsu_func_o(lsu_func_o),
        .lsu_st_en_o(lsu_st_en_o), .lsu_st_data_o(lsu_st_data_o),
        .lsu_ld_data_i(lsu_ld_data_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // LSU load data: random each cycle unless a directed test pins it.
    bit            ld_force = 1'b0;
    logic [DW-1:0] ld_force_val = '0;
    always @(posedge clk_i) begin
        #1;
        lsu_ld_data_i = ld_force ? ld_force_val : DW'($urandom);
    end

    function automatic bit exp_err(input logic [AW-1:0] a, input logic [2:0] f, input bit wr);
        int region;
        bit misal;
        bit bad_f;
        region = int'(a[11:8]);
        misal  = (f == 3'b010 && a[1:0] != 2'b00) || ((f == 3'b001 || f == 3'b101) && a[0]);
        bad_f  = wr ? !(f inside {3'b000, 3'b001, 3'b010})
                    : !(f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        return (region >= 10) || (wr && region == 9) || misal || bad_f;
    endfunction

    // Timeline model: a transaction accepted in cycle T occupies fixed offsets
    // after T (LSU cycles, then a response), then the port is free again.
    int            cyc = 0;
    bit            m_busy = 1'b0;
    int            m_t = 0;
    bit            m_id, m_err, m_wr;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_func;
    logic [DW-1:0] m_wdata, m_rdata;
    int            starv = 0;

    always @(negedge clk_i) begin
        logic [1:0]    e_rdy, e_rv;
        logic          e_err, e_se;
        logic [DW-1:0] e_rdata, e_sd;
        logic [AW-1:0] e_la;
        logic [2:0]    e_lf;
        bit            was_idle, g0, g1;
        int            d, rsp_d;
        e_rdy = '0; e_rv = '0; e_err = 1'b0; e_se = 1'b0;
        e_rdata = '0; e_sd = '0; e_la = '0; e_lf = '0;
        was_idle = 1'b0; g0 = 1'b0; g1 = 1'b0; d = 0; rsp_d = -1;
        if (!rst_ni) begin
            m_busy = 1'b0;
            starv  = 0;
        end else begin
            was_idle = !m_busy;
            g1 = req1_valid_i && (!req0_valid_i || starv == MW);
            g0 = req0_valid_i && !g1;
            if (was_idle) begin
                e_rdy = {g1, g0};
            end else begin
                d     = cyc - m_t;
                rsp_d = m_err ? 1 : (m_wr ? 2 : 2 + LAT);
                if (d == rsp_d) begin
                    e_rv    = m_id ? 2'b10 : 2'b01;
                    e_err   = m_err;
                    e_rdata = (m_err || m_wr) ? '0 : m_rdata;
                end else begin
                    e_la = m_addr;
                    e_lf = m_func;
                    e_se = m_wr;
                    e_sd = m_wdata;
                    if (!m_wr && d == 1 + LAT) m_rdata = lsu_ld_data_i;
                end
            end
        end
        check("ready", {req1_ready_o, req0_ready_o}, e_rdy);
        check("rsp", {rsp1_valid_o, rsp0_valid_o, rsp_err_o, rsp_rdata_o}, {e_rv, e_err, e_rdata});
        check("lsu", {lsu_addr_o, lsu_func_o, lsu_st_en_o, lsu_st_data_o}, {e_la, e_lf, e_se, e_sd});
        if (rst_ni) begin
            if (was_idle && (g0 || g1)) begin
                m_busy  = 1'b1;
                m_t     = cyc;
                m_id    = g1;
                m_addr  = g1 ? req1_addr_i  : req0_addr_i;
                m_func  = g1 ? req1_func_i  : req0_func_i;
                m_wr    = g1 ? req1_wr_i    : req0_wr_i;
                m_wdata = g1 ? req1_wdata_i : req0_wdata_i;
                m_err   = exp_err(m_addr, m_func, m_wr);
            end else if (!was_idle && d == rsp_d) begin
                m_busy = 1'b0;
            end
            if (!req1_valid_i) starv = 0;
            else if (was_idle && g1) starv = 0;
            else if (was_idle && g0 && starv < MW) starv++;
        end
        cyc++;
    end

    // Raises valid for one requester and waits (bounded) for its handshake.
    // Returns one ns into the cycle after the handshake.
    task automatic issue(input bit id, input logic [AW-1:0] a, input logic [2:0] f,
                         input bit wr, input logic [DW-1:0] wd);
        bit got;
        got = 1'b0;
        @(posedge clk_i); #1;
        if (id) begin
            req1_addr_i = a; req1_func_i = f; req1_wr_i = wr; req1_wdata_i = wd; req1_valid_i = 1'b1;
        end else begin
            req0_addr_i = a; req0_func_i = f; req0_wr_i = wr; req0_wdata_i = wd; req0_valid_i = 1'b1;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (id ? req1_ready_o : req0_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: requester %0d got no ready within 30 cycles", id);
        end
        @(posedge clk_i); #1;
        if (id) req1_valid_i = 1'b0;
        else    req0_valid_i = 1'b0;
    endtask

    typedef struct {
        bit            id;
        logic [AW-1:0] addr;
        logic [2:0]    func;
        bit            wr;
    } vec_t;

    vec_t errs[3] = '{
        '{1'b0, 32'h0000_0102, 3'b010, 1'b0},
        '{1'b0, 32'h0000_0A00, 3'b010, 1'b1},
        '{1'b0, 32'h0000_0900, 3'b010, 1'b1}
    };

    vec_t misc[8] = '{
        '{1'b1, 32'h0000_0103, 3'b100, 1'b0},
        '{1'b0, 32'h0000_0101, 3'b101, 1'b0},
        '{1'b0, 32'h0000_0010, 3'b100, 1'b1},
        '{1'b1, 32'h0000_0020, 3'b011, 1'b0},
        '{1'b0, 32'h0000_08FC, 3'b010, 1'b0},
        '{1'b1, 32'h0000_00FE, 3'b001, 1'b1},
        '{1'b0, 32'h0000_0040, 3'b110, 1'b0},
        '{1'b1, 32'h0000_09F0, 3'b000, 1'b0}
    };

    initial begin
        int            n;
        logic [9:0]    grants;
        int            ng;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        req0_addr_i = 32'h200; req0_func_i = 3'b010; req0_wr_i = 1'b0; req0_wdata_i = '0;
        req1_addr_i = 32'h300; req1_func_i = 3'b000; req1_wr_i = 1'b1; req1_wdata_i = 32'h1;

        // Reset held with both requesters valid.
        repeat (3) begin
            @(negedge clk_i);
            check("rst_outs", {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o,
                               rsp_rdata_o, lsu_addr_o, lsu_func_o, lsu_st_en_o, lsu_st_data_o}, '0);
        end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_rel_ready0", {req1_ready_o, req0_ready_o}, 2'b01);
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;

        // Word store from requester 0.
        issue(1'b0, 32'h0000_0104, 3'b010, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk_i);
        check("st_lsu", {lsu_addr_o, lsu_st_en_o, lsu_st_data_o}, {32'h104, 1'b1, 32'hDEAD_BEEF});
        // A requester-1 valid raised during the transaction and dropped before IDLE has no effect.
        req1_addr_i = 32'h0; req1_func_i = 3'b000; req1_wr_i = 1'b0; req1_valid_i = 1'b1;
        @(negedge clk_i);
        check("st_rsp", {rsp0_valid_o, rsp1_valid_o, rsp_err_o, rsp_rdata_o}, {1'b1, 1'b0, 1'b0, 32'h0});
        check("st_no_ready_in_resp", {req1_ready_o, req0_ready_o}, 2'b00);
        @(posedge clk_i); #1 req1_valid_i = 1'b0;

        // Word load from requester 1; only the T+2 data value may be returned.
        ld_force = 1'b1; ld_force_val = 32'h11;
        issue(1'b1, 32'h0000_0900, 3'b010, 1'b0, 32'h0);
        @(negedge clk_i);
        check("ld_lsu_t1", {lsu_addr_o, lsu_func_o, lsu_st_en_o}, {32'h900, 3'b010, 1'b0});
        ld_force_val = 32'hA5;
        @(negedge clk_i);
        check("ld_lsu_t2", {lsu_addr_o, lsu_st_en_o}, {32'h900, 1'b0});
        ld_force_val = 32'h22;
        @(negedge clk_i);
        check("ld_rsp", {rsp1_valid_o, rsp0_valid_o, rsp_err_o, rsp_rdata_o}, {1'b1, 1'b0, 1'b0, 32'hA5});
        ld_force = 1'b0;

        // Rejected requests answer at T+1 without touching the LSU.
        foreach (errs[i]) begin
            issue(errs[i].id, errs[i].addr, errs[i].func, errs[i].wr, 32'h5555_AAAA);
            @(negedge clk_i);
            check("err_rsp", {rsp0_valid_o, rsp_err_o, rsp_rdata_o}, {1'b1, 1'b1, 32'h0});
            check("err_lsu", {lsu_addr_o, lsu_func_o, lsu_st_en_o, lsu_st_data_o}, '0);
        end

        foreach (misc[i]) begin
            issue(misc[i].id, misc[i].addr, misc[i].func, misc[i].wr, 32'h1234_0000 + DW'(i));
        end

        // Both requesters hammer the port; requester 1 must win every fifth grant.
        @(posedge clk_i); #1;
        req0_addr_i = 32'h20; req0_func_i = 3'b010; req0_wr_i = 1'b1; req0_wdata_i = 32'h5;
        req1_addr_i = 32'h40; req1_func_i = 3'b010; req1_wr_i = 1'b1; req1_wdata_i = 32'h6;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        grants = '0;
        ng = 0;
        for (int c = 0; c < 200 && ng < 10; c++) begin
            @(negedge clk_i);
            if (req0_ready_o || req1_ready_o) begin
                grants[ng] = req1_ready_o;
                ng++;
            end
        end
        check("starv_grant_count", 32'(ng), 32'd10);
        check("starv_grant_order", grants, 10'b10_0001_0000);
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;

        // Reset while a load is in BUSY drops it.
        issue(1'b1, 32'h0000_0100, 3'b010, 1'b0, 32'h0);
        rst_ni = 1'b0;
        #1;
        check("midrst_outs", {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o,
                              rsp_rdata_o, lsu_addr_o, lsu_func_o, lsu_st_en_o, lsu_st_data_o}, '0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk_i);
            n += int'(rsp0_valid_o) + int'(rsp1_valid_o);
        end
        check("midrst_no_rsp", 32'(n), 32'd0);
        issue(1'b0, 32'h0000_0104, 3'b010, 1'b0, 32'h0);
        repeat (3) @(negedge clk_i);
        check("post_rst_rsp", {rsp0_valid_o, rsp1_valid_o, rsp_err_o}, 3'b100);

        repeat (4) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
